ddr3_wr_sched: RTL and testbench

DDR3_WR_SCHED -- requirements
Module: ddr3_wr_sched

---
 rtl/ddr3_phy_pkg.sv | 21 ++
 rtl/ddr3_wr_dly.sv | 28 ++
 rtl/ddr3_wr_sched.sv | 118 +++++++++++
 tb/tb_ddr3_wr_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ddr3_phy_pkg.sv
// Purpose: shared constants and sequencer state type for the DDR3 write datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr3_phy_pkg;

    // One BL8 burst occupies four controller clocks at two beats per clock.
    localparam int BL_CYCLES = 4;

    // Supported write-latency range in controller clocks.
    localparam int CWL_MIN = 2;
    localparam int CWL_MAX = 8;

    // Phase of the DQ/DQS bus in a given cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        BURST = 2'd2,
        POST  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/ddr3_wr_dly.sv
// Purpose: in-flight tracking; a tap line marking the age of every accepted WRITE.
// Latency: slot[0] is the acceptance itself, slot[k] is the acceptance k clocks ago.
// Backpressure: none; at most one start per clock, so the line can never overflow.
module ddr3_wr_dly
    import ddr3_phy_pkg::*;
#(
    parameter int DEPTH = 9
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic [DEPTH-1:0] slot
);

    logic [DEPTH-2:0] sr;

    // Shift the burst-start markers one age step per clock; reset drops every pending burst.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-3:0], start};
        end
    end

    assign slot = {sr, start};

endmodule

// File: rtl/ddr3_wr_sched.sv
// Purpose: DDR3 write scheduler; FIFO read strobes and DQ/DQS drive with pre/postamble.
// Latency: data on DQ in cycles CWL..CWL+3 after acceptance; FIFO read CWL-2..CWL+1.
// Backpressure: cmd_ready_o drops for 3 clocks after each acceptance (BL8 spacing).
module ddr3_wr_sched
    import ddr3_phy_pkg::*;
#(
    parameter int DQ_WIDTH = 8,
    parameter int CWL      = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    output logic                  wr_req_o,
    input  logic [2*DQ_WIDTH-1:0] wr_data_i,
    output logic [DQ_WIDTH-1:0]   dq_d0_o,
    output logic [DQ_WIDTH-1:0]   dq_d1_o,
    output logic                  dq_oen_o,
    output logic                  dqs_d0_o,
    output logic                  dqs_d1_o,
    output logic                  dqs_oen_o,
    output logic                  busy_o
);

    // Ages 0..CWL+3 cover everything from acceptance to the postamble.
    localparam int SLOTS = CWL + BL_CYCLES;
    // First age whose FIFO read can still be registered; CWL=2 needs an age -1 read.
    localparam int RQ_LO = (CWL >= 3) ? CWL - 3 : 0;

    logic             accept;
    logic [SLOTS-1:0] slot;
    seq_state_t       state, state_nxt;
    logic             ready_nxt, req_nxt, data_nxt, pre_nxt, post_nxt, busy_nxt;
    logic             req_q;

    assign accept = cmd_valid_i & cmd_ready_o;

    ddr3_wr_dly #(.DEPTH(SLOTS)) u_dly (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (accept),
        .slot    (slot)
    );

    // Decode what next cycle needs from the age of every burst in flight.
    always_comb begin
        ready_nxt = 1'b1;
        req_nxt   = 1'b0;
        data_nxt  = 1'b0;
        for (int k = 0; k < BL_CYCLES - 1; k++) begin
            if (slot[k]) ready_nxt = 1'b0;
        end
        for (int k = RQ_LO; k <= CWL; k++) begin
            if (slot[k]) req_nxt = 1'b1;
        end
        for (int k = CWL - 1; k <= CWL + 2; k++) begin
            if (slot[k]) data_nxt = 1'b1;
        end
        pre_nxt  = slot[CWL-2];
        post_nxt = slot[CWL+3];
        busy_nxt = |slot;
    end

    // Bus-phase register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus-phase transitions; a spacing-5 gap (postamble merged with preamble) goes straight to PRE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pre_nxt ? PRE : IDLE;
            PRE:     state_nxt = BURST;
            BURST: begin
                if (data_nxt)     state_nxt = BURST;
                else if (pre_nxt) state_nxt = PRE;
                else              state_nxt = POST;
            end
            POST:    state_nxt = pre_nxt ? PRE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, driven from the phase the bus enters next.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_o <= 1'b0;
            req_q       <= 1'b0;
            busy_o      <= 1'b0;
            dq_oen_o    <= 1'b1;
            dqs_oen_o   <= 1'b1;
            dqs_d0_o    <= 1'b0;
            dq_d0_o     <= '0;
            dq_d1_o     <= '0;
        end else begin
            cmd_ready_o <= ready_nxt;
            req_q       <= req_nxt;
            busy_o      <= busy_nxt;
            dq_oen_o    <= (state_nxt != BURST);
            dqs_oen_o   <= (state_nxt == IDLE);
            dqs_d0_o    <= (state_nxt == BURST);
            dq_d0_o     <= (state_nxt == BURST) ? wr_data_i[DQ_WIDTH-1:0] : '0;
            dq_d1_o     <= (state_nxt == BURST) ? wr_data_i[2*DQ_WIDTH-1:DQ_WIDTH] : '0;
        end
    end

    // DQS falls mid-clock in every driven cycle, so its falling-edge half is always low.
    assign dqs_d1_o = 1'b0;

    // With CWL=2 the first FIFO read lands in the acceptance cycle itself and cannot be registered.
    assign wr_req_o = req_q | ((CWL == 2) && accept);

endmodule

// File: tb/tb_ddr3_wr_sched.sv
// Purpose: self-checking bench for ddr3_wr_sched at CWL=5, DQ_WIDTH=8.
// Latency: checks every output once per cycle against windows derived from acceptance times.
// Backpressure: cmd_valid_i patterns exercise ignored requests while cmd_ready_o is low.
module tb_ddr3_wr_sched;

    localparam int DQW = 8;
    localparam int CWL = 5;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic             wr_req_o;
    logic [2*DQW-1:0] wr_data_i = '0;
    logic [DQW-1:0]   dq_d0_o;
    logic [DQW-1:0]   dq_d1_o;
    logic             dq_oen_o;
    logic             dqs_d0_o;
    logic             dqs_d1_o;
    logic             dqs_oen_o;
    logic             busy_o;

    int checks   = 0;
    int failures = 0;

    logic [2*DQW-1:0] sb_q[$];

    ddr3_wr_sched #(.DQ_WIDTH(DQW), .CWL(CWL)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .wr_req_o    (wr_req_o),
        .wr_data_i   (wr_data_i),
        .dq_d0_o     (dq_d0_o),
        .dq_d1_o     (dq_d1_o),
        .dq_oen_o    (dq_oen_o),
        .dqs_d0_o    (dqs_d0_o),
        .dqs_d1_o    (dqs_d1_o),
        .dqs_oen_o   (dqs_oen_o),
        .busy_o      (busy_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int j);
        logic [31:0] v;
        v = j * 17;
        return v[7:0];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_req"},     {31'd0, wr_req_o}, 32'd0);
        chk({tag, "_busy"},    {31'd0, busy_o}, 32'd0);
        chk({tag, "_dq_oen"},  {31'd0, dq_oen_o}, 32'd1);
        chk({tag, "_dqs_oen"}, {31'd0, dqs_oen_o}, 32'd1);
        chk({tag, "_data"},    {13'd0, dq_d1_o, dq_d0_o, dqs_d0_o, dqs_d1_o}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        cmd_valid_i = 1'b0;
        wr_data_i   = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk_idle("rst");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_release", {31'd0, cmd_ready_o}, 32'd1);
        @(negedge clock);
    endtask

    // Scenario runner: vpat = cmd_valid_i per cycle, acc = cycles where acceptance is expected.
    task automatic run_scn(input string nm, input logic [63:0] vpat, input logic [63:0] acc,
                           input int ncyc, input int rst_at);
        int               j = 1;
        int               nreq = 0;
        logic             prev_req = 1'b0;
        logic [2*DQW-1:0] w;
        logic             e_rdy, e_req, e_dat, e_pre, e_post, e_busy;
        do_reset();
        sb_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            e_rdy = 1'b1; e_req = 1'b0; e_dat = 1'b0;
            e_pre = 1'b0; e_post = 1'b0; e_busy = 1'b0;
            for (int a = 0; a < c; a++) begin
                if (acc[a]) begin
                    int d;
                    d = c - a;
                    if (d >= 1 && d <= 3) e_rdy = 1'b0;
                    if (d >= CWL - 2 && d <= CWL + 1) e_req = 1'b1;
                    if (d >= CWL && d <= CWL + 3) e_dat = 1'b1;
                    if (d == CWL - 1) e_pre = 1'b1;
                    if (d == CWL + 4) e_post = 1'b1;
                    if (d >= 1 && d <= CWL + 4) e_busy = 1'b1;
                end
            end
            chk($sformatf("%s_ready_c%0d", nm, c),   {31'd0, cmd_ready_o}, {31'd0, e_rdy});
            chk($sformatf("%s_req_c%0d", nm, c),     {31'd0, wr_req_o}, {31'd0, e_req});
            chk($sformatf("%s_busy_c%0d", nm, c),    {31'd0, busy_o}, {31'd0, e_busy});
            chk($sformatf("%s_dq_oen_c%0d", nm, c),  {31'd0, dq_oen_o}, {31'd0, !e_dat});
            chk($sformatf("%s_dqs_oen_c%0d", nm, c), {31'd0, dqs_oen_o}, {31'd0, !(e_dat || e_pre || e_post)});
            chk($sformatf("%s_dqs_c%0d", nm, c),     {30'd0, dqs_d0_o, dqs_d1_o}, {30'd0, e_dat, 1'b0});
            if (!dq_oen_o) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("%s_sb_underflow_c%0d", nm, c), 32'd1, 32'd0);
                end else begin
                    w = sb_q.pop_front();
                    chk($sformatf("%s_dq_c%0d", nm, c), {16'd0, dq_d1_o, dq_d0_o}, {16'd0, w});
                end
            end else begin
                chk($sformatf("%s_dq_zero_c%0d", nm, c), {16'd0, dq_d1_o, dq_d0_o}, 32'd0);
            end
            if (wr_req_o) nreq++;

            if (c == rst_at) begin
                reset_n     = 1'b0;
                cmd_valid_i = 1'b0;
                #1;
                chk("midrst_ready", {31'd0, cmd_ready_o}, 32'd0);
                chk_idle("midrst");
                repeat (3) begin
                    @(posedge clock);
                    #1;
                    chk_idle("inrst");
                end
                @(negedge clock);
                reset_n = 1'b1;
                #1;
                chk("release_ready_before_edge", {31'd0, cmd_ready_o}, 32'd0);
                @(posedge clock);
                #1;
                chk("release_ready_after_edge", {31'd0, cmd_ready_o}, 32'd1);
                repeat (12) begin
                    @(negedge clock);
                    chk_idle("postrst");
                end
                return;
            end

            if (prev_req) begin
                w = {pat(j + 1), pat(j)};
                j += 2;
                sb_q.push_back(w);
                wr_data_i = w;
            end else begin
                wr_data_i = 16'($urandom);
            end
            prev_req    = wr_req_o;
            cmd_valid_i = vpat[c];
            if (cmd_valid_i) begin
                chk($sformatf("%s_accept_c%0d", nm, c), {31'd0, cmd_ready_o}, {31'd0, acc[c]});
            end
            @(negedge clock);
        end
        cmd_valid_i = 1'b0;
        chk({nm, "_sb_drained"}, sb_q.size(), 32'd0);
        chk({nm, "_req_count"}, nreq, 4 * $countones(acc));
    endtask

    initial begin
        run_scn("single", 64'h1,   64'h1,   16, -1);
        run_scn("b2b4",   64'h11,  64'h11,  20, -1);
        run_scn("gap5",   64'h25,  64'h21,  20, -1);
        run_scn("gap7",   64'h81,  64'h81,  22, -1);
        run_scn("hold",   64'h7FF, 64'h111, 24, -1);
        run_scn("reset",  64'h1,   64'h1,   16, 6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
